// File: rtl/airi5c_imm_arbiter.sv
// Two-port arbiter in front of a shared combinational immediate generator.
// Define AIRI5C_IMM_ARB_RR_EN for round-robin arbitration; default is fixed port-0 priority.
module airi5c_imm_arbiter #(
  parameter int unsigned XPR_LEN        = 32,
  parameter int unsigned IMM_TYPE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [XPR_LEN-1:0]        req0_inst,
  input  logic [IMM_TYPE_WIDTH-1:0] req0_imm_type,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [XPR_LEN-1:0]        req1_inst,
  input  logic [IMM_TYPE_WIDTH-1:0] req1_imm_type,
  output logic                      rsp0_valid,
  input  logic                      rsp0_ready,
  output logic                      rsp1_valid,
  input  logic                      rsp1_ready,
  output logic [XPR_LEN-1:0]        rsp_imm,
  output logic [XPR_LEN-1:0]        gen_inst,
  output logic [IMM_TYPE_WIDTH-1:0] gen_imm_type,
  input  logic [XPR_LEN-1:0]        gen_imm,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                      state, state_nxt;
  logic                        owner, owner_nxt;
  logic                        grant;
  logic                        rsp0_valid_nxt, rsp1_valid_nxt, busy_nxt;
  logic [XPR_LEN-1:0]          rsp_imm_nxt, gen_inst_nxt;
  logic [IMM_TYPE_WIDTH-1:0]   gen_imm_type_nxt;
`ifdef AIRI5C_IMM_ARB_RR_EN
  logic                        last_grant, last_grant_nxt;
`endif

  // Grant selection: a lone valid requester always wins; conflicts go by policy.
  always_comb begin
    grant = 1'b0;
`ifdef AIRI5C_IMM_ARB_RR_EN
    if (req1_valid && (!req0_valid || !last_grant)) grant = 1'b1;
`else
    if (req1_valid && !req0_valid) grant = 1'b1;
`endif
  end

  assign req0_ready = (state == IDLE) && !grant;
  assign req1_ready = (state == IDLE) &&  grant;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    rsp0_valid_nxt   = rsp0_valid;
    rsp1_valid_nxt   = rsp1_valid;
    rsp_imm_nxt      = rsp_imm;
    gen_inst_nxt     = gen_inst;
    gen_imm_type_nxt = gen_imm_type;
`ifdef AIRI5C_IMM_ARB_RR_EN
    last_grant_nxt   = last_grant;
`endif
    case (state)
      IDLE: begin
        if (req0_valid && req0_ready) begin
          gen_inst_nxt     = req0_inst;
          gen_imm_type_nxt = req0_imm_type;
          owner_nxt        = 1'b0;
          state_nxt        = EVAL;
`ifdef AIRI5C_IMM_ARB_RR_EN
          last_grant_nxt   = 1'b0;
`endif
        end else if (req1_valid && req1_ready) begin
          gen_inst_nxt     = req1_inst;
          gen_imm_type_nxt = req1_imm_type;
          owner_nxt        = 1'b1;
          state_nxt        = EVAL;
`ifdef AIRI5C_IMM_ARB_RR_EN
          last_grant_nxt   = 1'b1;
`endif
        end
      end
      EVAL: begin
        rsp_imm_nxt    = gen_imm;
        rsp0_valid_nxt = !owner;
        rsp1_valid_nxt = owner;
        state_nxt      = RESP;
      end
      RESP: begin
        if (owner ? rsp1_ready : rsp0_ready) begin
          rsp0_valid_nxt = 1'b0;
          rsp1_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        rsp0_valid_nxt = 1'b0;
        rsp1_valid_nxt = 1'b0;
        state_nxt      = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      busy         <= 1'b0;
      rsp_imm      <= '0;
      gen_inst     <= '0;
      gen_imm_type <= '0;
`ifdef AIRI5C_IMM_ARB_RR_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      rsp0_valid   <= rsp0_valid_nxt;
      rsp1_valid   <= rsp1_valid_nxt;
      busy         <= busy_nxt;
      rsp_imm      <= rsp_imm_nxt;
      gen_inst     <= gen_inst_nxt;
      gen_imm_type <= gen_imm_type_nxt;
`ifdef AIRI5C_IMM_ARB_RR_EN
      last_grant   <= last_grant_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_airi5c_imm_arbiter.sv
// Bench for airi5c_imm_arbiter: directed scenarios then randomized transactions
// checked against a transaction-level model and an RV32 immediate decoder.
module tb_airi5c_imm_arbiter;

  localparam int unsigned XL = 32;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XL-1:0] req0_inst, req1_inst;
  logic [TW-1:0] req0_imm_type, req1_imm_type;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [XL-1:0] rsp_imm, gen_inst, gen_imm;
  logic [TW-1:0] gen_imm_type;
  logic          busy;

  int   checks = 0;
  int   failures = 0;
  logic model_last;

  always #5 clk = ~clk;

  airi5c_imm_arbiter #(.XPR_LEN(XL), .IMM_TYPE_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_inst(req0_inst), .req0_imm_type(req0_imm_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_inst(req1_inst), .req1_imm_type(req1_imm_type),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_imm(rsp_imm), .gen_inst(gen_inst), .gen_imm_type(gen_imm_type),
    .gen_imm(gen_imm), .busy(busy)
  );

  // Standard RV32 immediate decoder: I=0, S=1, U=2, J=3.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [1:0] t);
    case (t)
      2'd0:    imm_gen = {{20{i[31]}}, i[31:20]};
      2'd1:    imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    imm_gen = {i[31:12], 12'b0};
      default: imm_gen = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  assign gen_imm = imm_gen(gen_inst, gen_imm_type);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction, entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic v0, input logic [31:0] i0, input logic [1:0] t0,
                         input logic v1, input logic [31:0] i1, input logic [1:0] t1,
                         input int hold, output logic [31:0] got);
    int          win;
    logic [31:0] exp;
`ifdef AIRI5C_IMM_ARB_RR_EN
    if (v0 && v1) win = model_last ? 0 : 1;
    else          win = v0 ? 0 : 1;
`else
    win = v0 ? 0 : 1;
`endif
    exp = (win == 0) ? imm_gen(i0, t0) : imm_gen(i1, t1);
    req0_valid = v0; req0_inst = i0; req0_imm_type = t0;
    req1_valid = v1; req1_inst = i1; req1_imm_type = t1;
    #1;
    check("winner_ready", 32'((win == 0) ? req0_ready : req1_ready), 32'd1);
    if (v0 && v1) check("loser_ready", 32'((win == 0) ? req1_ready : req0_ready), 32'd0);
    @(negedge clk);
    if (win == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("eval_busy", 32'(busy), 32'd1);
    check("eval_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("eval_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("gen_inst", gen_inst, (win == 0) ? i0 : i1);
    @(negedge clk);
    for (int c = 0; c <= hold; c++) begin
      check("rsp_valid", 32'({rsp0_valid, rsp1_valid}), (win == 0) ? 32'd2 : 32'd1);
      check("rsp_imm", rsp_imm, exp);
      check("resp_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("resp_busy", 32'(busy), 32'd1);
      if (c == hold) begin
        rsp0_ready = (win == 0); rsp1_ready = (win == 1);
      end else begin
        rsp0_ready = (win == 1); rsp1_ready = (win == 0);
      end
      @(negedge clk);
    end
    got = rsp_imm;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("done_busy", 32'(busy), 32'd0);
    check("done_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    model_last = (win == 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp_seq [4];
    logic [1:0]  sel;
    rst = 1'b1;
    req0_valid = 0; req0_inst = '0; req0_imm_type = '0;
    req1_valid = 0; req1_inst = '0; req1_imm_type = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("reset_rsp_imm", rsp_imm, 32'd0);
    check("reset_gen_inst", gen_inst, 32'd0);
    check("reset_gen_type", 32'(gen_imm_type), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Both ports always valid: imm 1 from port 0, imm 2 from port 1.
`ifdef AIRI5C_IMM_ARB_RR_EN
    exp_seq = '{32'd1, 32'd2, 32'd1, 32'd2};
`else
    exp_seq = '{32'd1, 32'd1, 32'd1, 32'd1};
`endif
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, 32'h00100093, 2'd0, 1'b1, 32'h00200093, 2'd0, 0, got);
      check("conflict_order", got, exp_seq[k]);
    end

    run_txn(1'b1, 32'hFFF00093, 2'd0, 1'b0, '0, 2'd0, 0, got);
    check("i_type_imm", got, 32'hFFFFFFFF);
    run_txn(1'b0, '0, 2'd0, 1'b1, 32'h123450B7, 2'd2, 0, got);
    check("u_type_imm", got, 32'h12345000);
    run_txn(1'b0, '0, 2'd0, 1'b1, 32'h0020A423, 2'd1, 0, got);
    check("s_type_imm", got, 32'h00000008);
    run_txn(1'b1, 32'hFFDFF06F, 2'd3, 1'b1, 32'h00000013, 2'd0, 5, got);
    check("j_type_held_imm", got, 32'hFFFFFFFC);

    // Reset while EVAL: the in-flight result must vanish.
    req0_valid = 1'b1; req0_inst = 32'h7FF00093; req0_imm_type = 2'd0;
    @(negedge clk);
    req0_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_eval_busy", 32'(busy), 32'd0);
    check("rst_eval_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_eval_gen_inst", gen_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_txn(1'b1, 32'h00500093, 2'd0, 1'b0, '0, 2'd0, 1, got);
    check("post_rst_imm", got, 32'd5);

    // Randomized traffic against the model.
    for (int k = 0; k < 30; k++) begin
      sel = 2'($urandom_range(1, 3));
      run_txn(sel[0], $urandom, 2'($urandom_range(0, 3)),
              sel[1], $urandom, 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
